// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } kd_state_t;

  localparam int KD_SYNC_STAGES = 2;

endpackage

// File: rtl/key_debounce_cell.sv
// One debounced key: 2-flop synchroniser, stability FSM/counter, optional hold counter.
// Optional long-press detection is built when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int CNT_MAX  = 500000,
  parameter int LONG_MAX = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [KD_SYNC_STAGES-1:0] sync_p;
  logic                      pressed;
  kd_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic                      cnt_done;

  // key_in is active-high here; the top maps board polarity before and after the cell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[KD_SYNC_STAGES-2:0], key_in};
    end
  end

  assign pressed  = sync_p[KD_SYNC_STAGES-1];
  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (pressed) begin
            state <= PRESS_PEND;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!pressed) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt_done) begin
            state       <= PRESSED;
            cnt         <= '0;
            key_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state <= RELEASE_PEND;
            cnt   <= CNT_W'(1);
          end
        end
        RELEASE_PEND: begin
          if (pressed) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt_done) begin
            state         <= RELEASED;
            cnt           <= '0;
            key_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_W = (LONG_MAX > 2) ? $clog2(LONG_MAX) : 1;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);

  logic [LONG_W-1:0] hold;
  logic              fired;
  logic              hold_clr;

  // Re-entering PRESSED from RELEASE_PEND is bounce and must not restart the hold time.
  assign hold_clr = cnt_done && (((state == PRESS_PEND) && pressed) ||
                                 ((state == RELEASE_PEND) && !pressed));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= '0;
      fired      <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (hold_clr) begin
        hold  <= '0;
        fired <= 1'b0;
      end else if ((state == PRESSED) || (state == RELEASE_PEND)) begin
        if (hold != LONG_LAST) begin
          hold <= hold + LONG_W'(1);
        end else if (!fired) begin
          fired      <= 1'b1;
          long_press <= 1'b1;
        end
      end
    end
  end
`else
  // LONG_MAX has no effect in this build; referenced only so the parameter stays live.
  assign long_press = (LONG_MAX > 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// WIDTH-bit push-button debouncer feeding the KEY PIO in_port.
// Long-press pulses are generated when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CNT_MAX    = 500000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int LONG_MAX   = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    logic key_in;
    logic key_level;

    // Cells run active-high; a released active-low key resets to 1 on key_out.
    assign key_in     = ACTIVE_LOW ? ~key_raw[i] : key_raw[i];
    assign key_out[i] = ACTIVE_LOW ? ~key_level : key_level;

    key_debounce_cell #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_cell (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_in        (key_in),
      .key_level     (key_level),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i])
    );
  end

endmodule
